// File: rtl/sr_ff_driver.sv
// rtl/sr_ff_driver.sv - S/R pulse driver with feedback confirmation for one sr_ff
module sr_ff_driver #(
  parameter int PULSE_CYCLES = 2,
  parameter int TIMEOUT      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_val,
  output logic req_ready,
  input  logic q_fb,
  input  logic q_not_fb,
  output logic S,
  output logic R,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int MAXP = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
  localparam int CW   = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] P_LOAD = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT, ST_RESP} state_t;

  state_t          r_state;
  logic            r_tgt;
  logic [CW-1:0]   r_pcnt;
  logic [CW-1:0]   r_tcnt;
  logic            r_s;
  logic            r_r;
  logic            r_done;
  logic            r_err;

  logic w_accept;
  logic w_req_good;
  logic w_fb_good;

  assign req_ready  = (r_state == ST_IDLE) & rst_n;
  assign w_accept   = req_valid & req_ready;
  // Requiring q_not_fb to be the complement rejects the q_fb == q_not_fb case.
  assign w_req_good = (q_fb == req_val) & (q_not_fb == ~req_val);
  assign w_fb_good  = (q_fb == r_tgt) & (q_not_fb == ~r_tgt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tgt   <= 1'b0;
      r_pcnt  <= '0;
      r_tcnt  <= '0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_s <= 1'b0;
          r_r <= 1'b0;
          if (w_accept) begin
            r_tgt <= req_val;
            if (w_req_good) begin
              r_state <= ST_RESP;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_PULSE;
              r_pcnt  <= P_LOAD;
              r_s     <= req_val;
              r_r     <= ~req_val;
            end
          end
        end
        ST_PULSE: begin
          if (r_pcnt <= ONE) begin
            r_state <= ST_WAIT;
            r_tcnt  <= '0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt - ONE;
          end
        end
        ST_WAIT: begin
          if (w_fb_good) begin
            r_state <= ST_RESP;
            r_done  <= 1'b1;
          end else if (r_tcnt == T_LAST) begin
            r_state <= ST_RESP;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + ONE;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
        end
      endcase
    end
  end

  assign S    = r_s;
  assign R    = r_r;
  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_sr_ff_driver.sv
// tb/tb_sr_ff_driver.sv - directed vector bench for sr_ff_driver with a behavioural sr_ff
module tb_sr_ff_driver;

  logic clk = 1'b0;
  logic rst_n, req_valid, req_val, req_ready;
  logic q_fb, q_not_fb, S, R, busy, done, err;

  logic m_q, m_load, m_load_val, f_en, f_q, f_qn;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sr_ff_driver #(.PULSE_CYCLES(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_val(req_val),
    .req_ready(req_ready), .q_fb(q_fb), .q_not_fb(q_not_fb),
    .S(S), .R(R), .busy(busy), .done(done), .err(err)
  );

  // Behavioural sr_ff: Q follows S/R at the clock edge; f_en overrides feedback.
  always @(posedge clk) begin
    if (m_load)  m_q <= m_load_val;
    else if (S)  m_q <= 1'b1;
    else if (R)  m_q <= 1'b0;
  end
  assign q_fb     = f_en ? f_q  : m_q;
  assign q_not_fb = f_en ? f_qn : ~m_q;

  typedef struct {
    logic init_q;
    logic f_en;
    logic f_q;
    logic f_qn;
    logic v;
    int   lat;
    int   s;
    int   r;
    logic e;
    logic chk_q;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_q(input logic v);
    m_load = 1'b1; m_load_val = v;
    @(negedge clk);
    m_load = 1'b0;
  endtask

  // Called just after a negedge; returns at the negedge where done is seen.
  task automatic run_cmd(input logic v, input logic hold, input logic hv,
                         output int lat, output int scnt, output int rcnt,
                         output logic e, output logic ovl, output logic rdy);
    int n;
    lat = -1; scnt = 0; rcnt = 0; e = 1'b0; ovl = 1'b0; rdy = 1'b0;
    req_valid = 1'b1; req_val = v;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = hold; req_val = hv;
    for (int c = 1; c <= 40; c++) begin
      if (S && R) ovl = 1'b1;
      if (req_ready) rdy = 1'b1;
      scnt += int'(S);
      rcnt += int'(R);
      if (done) begin
        lat = c;
        e   = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  int   lat, sc, rc;
  logic e, ovl, rdy;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  4, 2, 0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  4, 0, 2, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  1, 0, 0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, 0, 0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11, 2, 0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11, 2, 0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11, 0, 2, 1'b1, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_val = 1'b0;
    m_load = 1'b0; m_load_val = 1'b0; f_en = 1'b0; f_q = 1'b0; f_qn = 1'b0;
    load_q(1'b0);
    @(negedge clk);
    chk("rst_S", int'(S), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(req_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", int'(req_ready), 1);

    for (int i = 0; i < 7; i++) begin
      f_en = vecs[i].f_en; f_q = vecs[i].f_q; f_qn = vecs[i].f_qn;
      load_q(vecs[i].init_q);
      run_cmd(vecs[i].v, 1'b0, 1'b0, lat, sc, rc, e, ovl, rdy);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_s_cycles", i), sc, vecs[i].s);
      chk($sformatf("v%0d_r_cycles", i), rc, vecs[i].r);
      chk($sformatf("v%0d_err", i), int'(e), int'(vecs[i].e));
      chk($sformatf("v%0d_s_and_r", i), int'(ovl), 0);
      chk($sformatf("v%0d_ready_while_busy", i), int'(rdy), 0);
      if (vecs[i].chk_q) chk($sformatf("v%0d_final_q", i), int'(q_fb), int'(vecs[i].v));
      @(negedge clk);
      chk($sformatf("v%0d_ready_after_done", i), int'(req_ready), 1);
      chk($sformatf("v%0d_done_one_cycle", i), int'(done), 0);
    end
    f_en = 1'b0;

    // Held request during a set command must not disturb it, then clears Q.
    load_q(1'b0);
    run_cmd(1'b1, 1'b1, 1'b0, lat, sc, rc, e, ovl, rdy);
    chk("busy_first_latency", lat, 4);
    chk("busy_first_s", sc, 2);
    chk("busy_first_r_tgt_kept", rc, 0);
    chk("busy_ready_low", int'(rdy), 0);
    chk("busy_first_q", int'(q_fb), 1);
    run_cmd(1'b0, 1'b0, 1'b0, lat, sc, rc, e, ovl, rdy);
    chk("busy_second_latency", lat, 4);
    chk("busy_second_r", rc, 2);
    chk("busy_second_err", int'(e), 0);
    chk("busy_second_q", int'(q_fb), 0);

    // Reset in the first pulse cycle drops the command.
    @(negedge clk);
    load_q(1'b0);
    req_valid = 1'b1; req_val = 1'b1;
    @(negedge clk);
    chk("midrst_pulse_S", int'(S), 1);
    req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_S", int'(S), 0);
    chk("midrst_R", int'(R), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    @(negedge clk);
    chk("midrst_done_hold", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", int'(req_ready), 1);
    chk("midrst_no_done", int'(done), 0);
    load_q(1'b1);
    run_cmd(1'b0, 1'b0, 1'b0, lat, sc, rc, e, ovl, rdy);
    chk("postrst_latency", lat, 4);
    chk("postrst_r", rc, 2);
    chk("postrst_s", sc, 0);
    chk("postrst_err", int'(e), 0);
    chk("postrst_q", int'(q_fb), 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
